// File: rtl/decoder_pkg.sv
// Shared decoder types: opcodes, mux encodings, control bundle and scheduler core states.
package decoder_pkg;

  localparam int unsigned OPCODE_WIDTH = 4;

  typedef enum logic [3:0] {
    OP_NOP   = 4'h0,
    OP_BR    = 4'h1,
    OP_CMP   = 4'h2,
    OP_ADD   = 4'h3,
    OP_SUB   = 4'h4,
    OP_MUL   = 4'h5,
    OP_DIV   = 4'h6,
    OP_LDR   = 4'h7,
    OP_STR   = 4'h8,
    OP_CONST = 4'h9,
    OP_RET   = 4'hF
  } opcode_t;

  typedef enum logic [1:0] {
    RIN_ALU = 2'b00,
    RIN_MEM = 2'b01,
    RIN_IMM = 2'b10
  } reg_input_mux_t;

  typedef enum logic [1:0] {
    ALU_ADD = 2'b00,
    ALU_SUB = 2'b01,
    ALU_MUL = 2'b10,
    ALU_DIV = 2'b11
  } alu_arith_mux_t;

  typedef enum logic [2:0] {
    CORE_IDLE    = 3'd0,
    CORE_FETCH   = 3'd1,
    CORE_DECODE  = 3'd2,
    CORE_REQUEST = 3'd3,
    CORE_WAIT    = 3'd4,
    CORE_EXECUTE = 3'd5,
    CORE_UPDATE  = 3'd6,
    CORE_DONE    = 3'd7
  } core_state_t;

  typedef struct packed {
    logic           reg_write_enable;
    logic           mem_read_enable;
    logic           mem_write_enable;
    logic           nzp_write_enable;
    reg_input_mux_t reg_input_mux;
    alu_arith_mux_t alu_arithmetic_mux;
    logic           alu_output_mux;
    logic           pc_mux;
    logic           ret;
  } ctrl_t;

endpackage

// File: rtl/decoder_ctrl_rom.sv
// Combinational opcode -> control bundle map.
// DECODER_ILLEGAL_TRAP_EN: flags opcodes A..E as illegal; otherwise they decode as NOP.
module decoder_ctrl_rom
  import decoder_pkg::*;
(
  input  opcode_t opcode,
  output ctrl_t   ctrl_c,
  output logic    is_illegal_c
);

  always_comb begin
    ctrl_c       = '0;
    is_illegal_c = 1'b0;
    case (opcode)
      OP_BR:    ctrl_c.pc_mux = 1'b1;
      OP_CMP: begin
        ctrl_c.alu_output_mux   = 1'b1;
        ctrl_c.nzp_write_enable = 1'b1;
      end
      OP_ADD: begin
        ctrl_c.reg_write_enable   = 1'b1;
        ctrl_c.alu_arithmetic_mux = ALU_ADD;
      end
      OP_SUB: begin
        ctrl_c.reg_write_enable   = 1'b1;
        ctrl_c.alu_arithmetic_mux = ALU_SUB;
      end
      OP_MUL: begin
        ctrl_c.reg_write_enable   = 1'b1;
        ctrl_c.alu_arithmetic_mux = ALU_MUL;
      end
      OP_DIV: begin
        ctrl_c.reg_write_enable   = 1'b1;
        ctrl_c.alu_arithmetic_mux = ALU_DIV;
      end
      OP_LDR: begin
        ctrl_c.reg_write_enable = 1'b1;
        ctrl_c.reg_input_mux    = RIN_MEM;
        ctrl_c.mem_read_enable  = 1'b1;
      end
      OP_STR:   ctrl_c.mem_write_enable = 1'b1;
      OP_CONST: begin
        ctrl_c.reg_write_enable = 1'b1;
        ctrl_c.reg_input_mux    = RIN_IMM;
      end
      OP_RET:   ctrl_c.ret = 1'b1;
      default: ;
    endcase
`ifdef DECODER_ILLEGAL_TRAP_EN
    is_illegal_c = (4'(opcode) >= 4'hA) && (4'(opcode) <= 4'hE);
`else
    is_illegal_c = 1'b0;
`endif
  end

endmodule

// File: rtl/decoder_queue.sv
// Instruction decoder with a DEPTH-entry decoded-instruction queue; halts after RET until flush.
// DECODER_ILLEGAL_TRAP_EN: illegal opcodes are dropped and set a sticky trap (see decoder_ctrl_rom).
module decoder_queue
  import decoder_pkg::*;
#(
  parameter int unsigned INSTR_WIDTH   = 16,
  parameter int unsigned REG_ADDR_BITS = 4,
  parameter int unsigned IMM_WIDTH     = 8,
  parameter int unsigned DEPTH         = 2
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     flush,
  input  logic                     in_valid,
  output logic                     in_ready,
  input  logic [INSTR_WIDTH-1:0]   instruction,
  output logic                     out_valid,
  input  logic                     out_ready,
  output logic [REG_ADDR_BITS-1:0] decoded_rd_address,
  output logic [REG_ADDR_BITS-1:0] decoded_rs_address,
  output logic [REG_ADDR_BITS-1:0] decoded_rt_address,
  output logic [2:0]               decoded_nzp,
  output logic [IMM_WIDTH-1:0]     decoded_immediate,
  output logic                     decoded_reg_write_enable,
  output logic                     decoded_mem_read_enable,
  output logic                     decoded_mem_write_enable,
  output logic                     decoded_nzp_write_enable,
  output logic [1:0]               decoded_reg_input_mux,
  output logic [1:0]               decoded_alu_arithmetic_mux,
  output logic                     decoded_alu_output_mux,
  output logic                     decoded_pc_mux,
  output logic                     decoded_ret,
  output logic                     decoded_illegal
);

  localparam int unsigned PTR_W     = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int unsigned CNT_W     = $clog2(DEPTH + 1);
  localparam int unsigned PAYLOAD_W = INSTR_WIDTH - OPCODE_WIDTH;
  localparam int unsigned RD_MSB    = PAYLOAD_W - 1;
  localparam int unsigned RS_MSB    = RD_MSB - REG_ADDR_BITS;
  localparam int unsigned RT_MSB    = RS_MSB - REG_ADDR_BITS;

  // Opcode bits are not stored; the control bundle already captures them.
  typedef struct packed {
    logic [PAYLOAD_W-1:0] payload;
    ctrl_t                ctrl;
  } entry_t;

  entry_t             mem [DEPTH];
  logic [PTR_W-1:0]   wr_ptr, rd_ptr;
  logic [CNT_W-1:0]   count;
  logic               halted, illegal;

  ctrl_t              rom_ctrl;
  logic               rom_illegal;
  logic               push, enq, deq;
  entry_t             head;

  decoder_ctrl_rom u_ctrl_rom (
    .opcode       (opcode_t'(instruction[INSTR_WIDTH-1 -: OPCODE_WIDTH])),
    .ctrl_c       (rom_ctrl),
    .is_illegal_c (rom_illegal)
  );

  function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
    return (p == PTR_W'(DEPTH - 1)) ? '0 : p + PTR_W'(1);
  endfunction

  assign in_ready  = !reset && !flush && !halted && (count < CNT_W'(DEPTH));
  assign out_valid = !reset && (count != '0);
  assign push      = in_valid && in_ready;
  assign enq       = push && !rom_illegal;
  assign deq       = out_valid && out_ready;
  assign head      = mem[rd_ptr];

  // Pointer, occupancy and halt/trap state; reset and flush win over push/pop.
  always_ff @(posedge clk) begin
    if (reset || flush) begin
      wr_ptr  <= '0;
      rd_ptr  <= '0;
      count   <= '0;
      halted  <= 1'b0;
      illegal <= 1'b0;
    end else begin
      if (enq) wr_ptr <= ptr_inc(wr_ptr);
      if (deq) rd_ptr <= ptr_inc(rd_ptr);
      case ({enq, deq})
        2'b10:   count <= count + CNT_W'(1);
        2'b01:   count <= count - CNT_W'(1);
        default: ;
      endcase
      if (push && (rom_ctrl.ret || rom_illegal)) halted <= 1'b1;
      if (push && rom_illegal) illegal <= 1'b1;
    end
  end

  // Entry storage needs no reset: occupancy alone decides what is visible.
  always_ff @(posedge clk) begin
    if (enq) mem[wr_ptr] <= '{payload: instruction[PAYLOAD_W-1:0], ctrl: rom_ctrl};
  end

  // Head entry fields, forced to zero while the queue is empty.
  always_comb begin
    decoded_rd_address         = '0;
    decoded_rs_address         = '0;
    decoded_rt_address         = '0;
    decoded_nzp                = '0;
    decoded_immediate          = '0;
    decoded_reg_write_enable   = 1'b0;
    decoded_mem_read_enable    = 1'b0;
    decoded_mem_write_enable   = 1'b0;
    decoded_nzp_write_enable   = 1'b0;
    decoded_reg_input_mux      = '0;
    decoded_alu_arithmetic_mux = '0;
    decoded_alu_output_mux     = 1'b0;
    decoded_pc_mux             = 1'b0;
    decoded_ret                = 1'b0;
    if (out_valid) begin
      decoded_rd_address         = head.payload[RD_MSB -: REG_ADDR_BITS];
      decoded_rs_address         = head.payload[RS_MSB -: REG_ADDR_BITS];
      decoded_rt_address         = head.payload[RT_MSB -: REG_ADDR_BITS];
      decoded_nzp                = head.payload[RD_MSB -: 3];
      decoded_immediate          = head.payload[IMM_WIDTH-1:0];
      decoded_reg_write_enable   = head.ctrl.reg_write_enable;
      decoded_mem_read_enable    = head.ctrl.mem_read_enable;
      decoded_mem_write_enable   = head.ctrl.mem_write_enable;
      decoded_nzp_write_enable   = head.ctrl.nzp_write_enable;
      decoded_reg_input_mux      = head.ctrl.reg_input_mux;
      decoded_alu_arithmetic_mux = head.ctrl.alu_arithmetic_mux;
      decoded_alu_output_mux     = head.ctrl.alu_output_mux;
      decoded_pc_mux             = head.ctrl.pc_mux;
      decoded_ret                = head.ctrl.ret;
    end
  end

  assign decoded_illegal = illegal && !reset;

endmodule

// File: tb/tb_decoder_queue.sv
// Bench for decoder_queue: DEPTH 1/2/4 instances share stimulus; a queue model scores all three.
module tb_decoder_queue;

  localparam int unsigned NI = 3;

  typedef struct packed {
    logic        in_ready;
    logic        out_valid;
    logic [3:0]  rd;
    logic [3:0]  rs;
    logic [3:0]  rt;
    logic [2:0]  nzp;
    logic [7:0]  imm;
    logic [10:0] ctrl;
    logic        illegal;
  } obs_t;

  typedef struct {
    bit          rst;
    bit          fl;
    bit          iv;
    logic [15:0] ins;
    bit          ordy;
    bit          ir;
    bit          ov;
    logic [3:0]  rd;
    logic [7:0]  imm;
    logic [10:0] ctrl;
  } vec_t;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        flush = 1'b0;
  logic        in_valid = 1'b0;
  logic [15:0] instruction = '0;
  logic        out_ready = 1'b0;

  logic        w_in_ready [NI];
  logic        w_out_valid [NI];
  logic [3:0]  w_rd [NI];
  logic [3:0]  w_rs [NI];
  logic [3:0]  w_rt [NI];
  logic [2:0]  w_nzp [NI];
  logic [7:0]  w_imm [NI];
  logic        w_reg_we [NI];
  logic        w_mem_re [NI];
  logic        w_mem_we [NI];
  logic        w_nzp_we [NI];
  logic [1:0]  w_imux [NI];
  logic [1:0]  w_arith [NI];
  logic        w_aluo [NI];
  logic        w_pc [NI];
  logic        w_ret [NI];
  logic        w_ill [NI];

  int checks = 0;
  int errors = 0;

  logic [15:0] mq [NI][$];
  bit          m_halt [NI];
  bit          m_ill [NI];

  always #5 clk = ~clk;

  for (genvar g = 0; g < NI; g++) begin : g_dut
    decoder_queue #(
      .INSTR_WIDTH   (16),
      .REG_ADDR_BITS (4),
      .IMM_WIDTH     (8),
      .DEPTH         (g == 0 ? 1 : (g == 1 ? 2 : 4))
    ) u_dut (
      .clk                        (clk),
      .reset                      (reset),
      .flush                      (flush),
      .in_valid                   (in_valid),
      .in_ready                   (w_in_ready[g]),
      .instruction                (instruction),
      .out_valid                  (w_out_valid[g]),
      .out_ready                  (out_ready),
      .decoded_rd_address         (w_rd[g]),
      .decoded_rs_address         (w_rs[g]),
      .decoded_rt_address         (w_rt[g]),
      .decoded_nzp                (w_nzp[g]),
      .decoded_immediate          (w_imm[g]),
      .decoded_reg_write_enable   (w_reg_we[g]),
      .decoded_mem_read_enable    (w_mem_re[g]),
      .decoded_mem_write_enable   (w_mem_we[g]),
      .decoded_nzp_write_enable   (w_nzp_we[g]),
      .decoded_reg_input_mux      (w_imux[g]),
      .decoded_alu_arithmetic_mux (w_arith[g]),
      .decoded_alu_output_mux     (w_aluo[g]),
      .decoded_pc_mux             (w_pc[g]),
      .decoded_ret                (w_ret[g]),
      .decoded_illegal            (w_ill[g])
    );
  end

  function automatic int unsigned depth_of(input int i);
    return (i == 0) ? 1 : ((i == 1) ? 2 : 4);
  endfunction

  // Control vector: {reg_we, mem_re, mem_we, nzp_we, input_mux[1:0], arith[1:0], alu_out, pc, ret}
  function automatic logic [10:0] ref_ctrl(input logic [15:0] ins);
    case (ins[15:12])
      4'h1:    return 11'h002;
      4'h2:    return 11'h084;
      4'h3:    return 11'h400;
      4'h4:    return 11'h408;
      4'h5:    return 11'h410;
      4'h6:    return 11'h418;
      4'h7:    return 11'h620;
      4'h8:    return 11'h100;
      4'h9:    return 11'h440;
      4'hF:    return 11'h001;
      default: return 11'h000;
    endcase
  endfunction

  function automatic bit ref_illegal(input logic [15:0] ins);
`ifdef DECODER_ILLEGAL_TRAP_EN
    return (ins[15:12] >= 4'hA) && (ins[15:12] <= 4'hE);
`else
    return 1'b0;
`endif
  endfunction

  function automatic obs_t get_obs(input int i);
    obs_t o;
    o.in_ready  = w_in_ready[i];
    o.out_valid = w_out_valid[i];
    o.rd        = w_rd[i];
    o.rs        = w_rs[i];
    o.rt        = w_rt[i];
    o.nzp       = w_nzp[i];
    o.imm       = w_imm[i];
    o.ctrl      = {w_reg_we[i], w_mem_re[i], w_mem_we[i], w_nzp_we[i], w_imux[i],
                   w_arith[i], w_aluo[i], w_pc[i], w_ret[i]};
    o.illegal   = w_ill[i];
    return o;
  endfunction

  function automatic obs_t expected(input int i);
    obs_t        e;
    logic [15:0] h;
    e = '0;
    if (!reset) begin
      e.in_ready  = !flush && !m_halt[i] && (mq[i].size() < depth_of(i));
      e.out_valid = mq[i].size() != 0;
      if (e.out_valid) begin
        h     = mq[i][0];
        e.rd  = h[11:8];
        e.rs  = h[7:4];
        e.rt  = h[3:0];
        e.nzp = h[11:9];
        e.imm = h[7:0];
        e.ctrl = ref_ctrl(h);
      end
      e.illegal = m_ill[i];
    end
    return e;
  endfunction

  task automatic check(input string name, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%h expected=%h at %0t", name, got, exp, $time);
    end
  endtask

  // Scoreboard update from the expected handshake state seen this cycle.
  task automatic model_update(input int i, input obs_t e);
    if (reset || flush) begin
      mq[i].delete();
      m_halt[i] = 1'b0;
      m_ill[i]  = 1'b0;
    end else begin
      if (e.out_valid && out_ready) void'(mq[i].pop_front());
      if (in_valid && e.in_ready) begin
        if (ref_illegal(instruction)) begin
          m_halt[i] = 1'b1;
          m_ill[i]  = 1'b1;
        end else begin
          mq[i].push_back(instruction);
          if (instruction[15:12] == 4'hF) m_halt[i] = 1'b1;
        end
      end
    end
  endtask

  // One clock: sample on negedge, score every instance, advance the model, step past posedge.
  task automatic cycle(output obs_t d2);
    obs_t ex [NI];
    obs_t got;
    @(negedge clk);
    for (int i = 0; i < NI; i++) begin
      ex[i] = expected(i);
      got   = get_obs(i);
      check($sformatf("model_d%0d", depth_of(i)), 64'(got), 64'(ex[i]));
      if (i == 1) d2 = got;
    end
    for (int i = 0; i < NI; i++) model_update(i, ex[i]);
    @(posedge clk);
    #1;
  endtask

  function automatic vec_t mk(input bit rst, input bit fl, input bit iv, input logic [15:0] ins,
                              input bit ordy, input bit ir, input bit ov, input logic [3:0] rd,
                              input logic [7:0] imm, input logic [10:0] ctrl);
    vec_t v;
    v.rst = rst; v.fl = fl; v.iv = iv; v.ins = ins; v.ordy = ordy;
    v.ir = ir; v.ov = ov; v.rd = rd; v.imm = imm; v.ctrl = ctrl;
    return v;
  endfunction

  initial begin
    vec_t tbl[$];
    obs_t d;

    for (int i = 0; i < NI; i++) begin
      m_halt[i] = 1'b0;
      m_ill[i]  = 1'b0;
    end

    // Expected columns describe the DEPTH=2 instance during that cycle.
    //                rst fl iv ins      ordy ir ov rd    imm    ctrl
    tbl.push_back(mk(1, 0, 0, 16'h0000, 0, 0, 0, 4'h0, 8'h00, 11'h000));
    tbl.push_back(mk(0, 0, 1, 16'h3123, 1, 1, 0, 4'h0, 8'h00, 11'h000));
    tbl.push_back(mk(0, 0, 0, 16'h0000, 1, 1, 1, 4'h1, 8'h23, 11'h400));
    tbl.push_back(mk(0, 0, 0, 16'h0000, 0, 1, 0, 4'h0, 8'h00, 11'h000));
    tbl.push_back(mk(0, 0, 1, 16'h9105, 0, 1, 0, 4'h0, 8'h00, 11'h000));
    tbl.push_back(mk(0, 0, 1, 16'h7230, 0, 1, 1, 4'h1, 8'h05, 11'h440));
    tbl.push_back(mk(0, 0, 0, 16'h0000, 1, 0, 1, 4'h1, 8'h05, 11'h440));
    tbl.push_back(mk(0, 0, 0, 16'h0000, 0, 1, 1, 4'h2, 8'h30, 11'h620));
    tbl.push_back(mk(0, 0, 0, 16'h0000, 1, 1, 1, 4'h2, 8'h30, 11'h620));
    tbl.push_back(mk(0, 0, 1, 16'hF000, 0, 1, 0, 4'h0, 8'h00, 11'h000));
    tbl.push_back(mk(0, 0, 1, 16'h3123, 0, 0, 1, 4'h0, 8'h00, 11'h001));
    tbl.push_back(mk(0, 0, 1, 16'h3123, 1, 0, 1, 4'h0, 8'h00, 11'h001));
    tbl.push_back(mk(0, 0, 1, 16'h3123, 0, 0, 0, 4'h0, 8'h00, 11'h000));
    tbl.push_back(mk(0, 1, 1, 16'h3123, 0, 0, 0, 4'h0, 8'h00, 11'h000));
    tbl.push_back(mk(0, 0, 1, 16'h3123, 0, 1, 0, 4'h0, 8'h00, 11'h000));
    tbl.push_back(mk(0, 0, 0, 16'h0000, 0, 1, 1, 4'h1, 8'h23, 11'h400));
    tbl.push_back(mk(0, 0, 1, 16'h4321, 0, 1, 1, 4'h1, 8'h23, 11'h400));
    tbl.push_back(mk(0, 1, 1, 16'h3123, 1, 0, 1, 4'h1, 8'h23, 11'h400));
    tbl.push_back(mk(0, 0, 0, 16'h0000, 0, 1, 0, 4'h0, 8'h00, 11'h000));
    tbl.push_back(mk(0, 0, 1, 16'h8456, 0, 1, 0, 4'h0, 8'h00, 11'h000));
    tbl.push_back(mk(0, 0, 0, 16'h0000, 0, 1, 1, 4'h4, 8'h56, 11'h100));
    tbl.push_back(mk(1, 0, 1, 16'h3123, 1, 0, 0, 4'h0, 8'h00, 11'h000));
    tbl.push_back(mk(0, 0, 0, 16'h0000, 0, 1, 0, 4'h0, 8'h00, 11'h000));
    tbl.push_back(mk(0, 0, 1, 16'h2ABC, 1, 1, 0, 4'h0, 8'h00, 11'h000));
    tbl.push_back(mk(0, 0, 1, 16'h1E0F, 1, 1, 1, 4'hA, 8'hBC, 11'h084));
    tbl.push_back(mk(0, 0, 1, 16'h5111, 1, 1, 1, 4'hE, 8'h0F, 11'h002));
    tbl.push_back(mk(0, 0, 1, 16'h6222, 1, 1, 1, 4'h1, 8'h11, 11'h410));
    tbl.push_back(mk(0, 0, 0, 16'h0000, 1, 1, 1, 4'h2, 8'h22, 11'h418));
    tbl.push_back(mk(0, 0, 0, 16'h0000, 0, 1, 0, 4'h0, 8'h00, 11'h000));

    #1;
    foreach (tbl[k]) begin
      reset       = tbl[k].rst;
      flush       = tbl[k].fl;
      in_valid    = tbl[k].iv;
      instruction = tbl[k].ins;
      out_ready   = tbl[k].ordy;
      cycle(d);
      check($sformatf("vec%0d", k), 64'({d.in_ready, d.out_valid, d.rd, d.imm, d.ctrl}),
            64'({tbl[k].ir, tbl[k].ov, tbl[k].rd, tbl[k].imm, tbl[k].ctrl}));
    end

    // Opcode A: trapped and dropped, or enqueued as a NOP.
    reset = 1'b0; flush = 1'b0; out_ready = 1'b0;
    in_valid = 1'b1; instruction = 16'hA000;
    cycle(d);
    check("illegal_accept", 64'(d.in_ready), 64'd1);
    in_valid = 1'b0;
    cycle(d);
`ifdef DECODER_ILLEGAL_TRAP_EN
    check("illegal_trap", 64'({d.in_ready, d.out_valid, d.illegal, d.ctrl}), 64'({3'b001, 11'h000}));
`else
    check("illegal_nop", 64'({d.in_ready, d.out_valid, d.illegal, d.ctrl}), 64'({3'b110, 11'h000}));
`endif
    in_valid = 1'b1; instruction = 16'h3123;
    cycle(d);
`ifdef DECODER_ILLEGAL_TRAP_EN
    check("illegal_hold", 64'({d.in_ready, d.illegal}), 64'({1'b0, 1'b1}));
`else
    check("illegal_hold", 64'({d.in_ready, d.illegal}), 64'({1'b1, 1'b0}));
`endif
    in_valid = 1'b0; flush = 1'b1;
    cycle(d);
    flush = 1'b0;
    cycle(d);
    check("illegal_cleared", 64'({d.in_ready, d.out_valid, d.illegal}), 64'({1'b1, 1'b0, 1'b0}));

    // Random traffic across pointer wrap on all depths.
    for (int n = 0; n < 300; n++) begin
      flush       = ($urandom_range(15) == 0);
      in_valid    = $urandom_range(1);
      out_ready   = ($urandom_range(2) != 0);
      instruction = 16'($urandom);
      cycle(d);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
